// File: rtl/tge_tx_snap_ctrl_pkg.sv
// Shared types and bit positions for the 10GbE TX snapshot capture sequencer.
package tge_snap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } snap_state_t;

  localparam int CTRL_ARM        = 0;
  localparam int CTRL_TRIG_MODE  = 1;
  localparam int CTRL_VALID_GATE = 2;

  localparam int ST_DONE = 31;
  localparam int ST_BUSY = 30;

endpackage

// File: rtl/tge_tx_snap_ctrl_if.sv
// TX stream in and snapshot BRAM write port out, bundled for the capture sequencer.
interface tge_tx_snap_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              ext_trig;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;

  modport master (
    output tx_data, tx_valid, ext_trig,
    input  bram_we, bram_addr, bram_din
  );

  modport slave (
    input  tx_data, tx_valid, ext_trig,
    output bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/tge_tx_snap_ctrl.sv
// Snapshot capture sequencer: arms on a ctrl[0] rising edge, triggers immediately or on
// ext_trig, writes a 2^ADDR_W word window into the snapshot BRAM and reports progress.
//
// state   | meaning
// IDLE    | after reset, waiting for first arm edge
// ARMED   | waiting for trigger; count is 0
// CAPTURE | writing one word per eligible cycle
// DONE    | window full, holds until next arm edge
module tge_tx_snap_ctrl
  import tge_snap_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl,
  tge_tx_snap_ctrl_if.slave snap,
  output logic [31:0]       snap_addr
);

  localparam int CNT_W = ADDR_W + 1;

  snap_state_t      state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             arm_q;
  logic             primed;
  logic             arm;
  logic             eligible;
  logic             trig;
  logic             last;
  logic             we_nxt;
  logic [28:0]      ctrl_unused;

  assign ctrl_unused = ctrl[31:3];

  // primed stays low for the first cycle out of reset so a level already high is not an edge
  assign arm      = primed & ctrl[CTRL_ARM] & ~arm_q;
  assign eligible = ctrl[CTRL_VALID_GATE] ? snap.tx_valid : 1'b1;
  assign trig     = eligible & (~ctrl[CTRL_TRIG_MODE] | snap.ext_trig);
  assign last     = &count[ADDR_W-1:0];

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    we_nxt    = 1'b0;
    if (arm) begin
      state_nxt = ARMED;
      count_nxt = '0;
    end else begin
      case (state)
        ARMED: begin
          if (trig) begin
            we_nxt    = 1'b1;
            count_nxt = count + CNT_W'(1);
            state_nxt = last ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (eligible) begin
            we_nxt    = 1'b1;
            count_nxt = count + CNT_W'(1);
            state_nxt = last ? DONE : CAPTURE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state          <= IDLE;
      count          <= '0;
      arm_q          <= 1'b0;
      primed         <= 1'b0;
      snap.bram_we   <= 1'b0;
      snap.bram_addr <= '0;
      snap.bram_din  <= '0;
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      arm_q         <= ctrl[CTRL_ARM];
      primed        <= 1'b1;
      snap.bram_we  <= we_nxt;
      snap.bram_din <= snap.tx_data;
      if (we_nxt) snap.bram_addr <= count[ADDR_W-1:0];
    end
  end

  always_comb begin
    snap_addr          = '0;
    snap_addr[ST_DONE] = (state == DONE);
    snap_addr[ST_BUSY] = (state == ARMED) || (state == CAPTURE);
    snap_addr[CNT_W-1:0] = count;
  end

endmodule

// File: tb/tb_tge_tx_snap_ctrl.sv
// Directed bench for the TX snapshot sequencer with a 16-word window.
module tb_tge_tx_snap_ctrl;
  import tge_snap_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 64;

  logic        user_clk;
  logic        user_rst;
  logic [31:0] ctrl;
  logic [31:0] snap_addr;

  int n_checks;
  int n_errors;

  tge_tx_snap_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) snap_bus ();

  tge_tx_snap_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .user_clk  (user_clk),
    .user_rst  (user_rst),
    .ctrl      (ctrl),
    .snap      (snap_bus),
    .snap_addr (snap_addr)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic check_write(input string tag, input int addr, input logic [63:0] data);
    check({tag, " we"}, {63'd0, snap_bus.bram_we}, 64'd1);
    check({tag, " addr"}, {60'd0, snap_bus.bram_addr}, 64'(addr));
    check({tag, " din"}, snap_bus.bram_din, data);
  endtask

  task automatic check_idle_we(input string tag);
    check({tag, " we"}, {63'd0, snap_bus.bram_we}, 64'd0);
  endtask

  function automatic logic [31:0] busy_word(input int words);
    return 32'h4000_0000 | 32'(words);
  endfunction

  initial begin
    int writes;
    int words;
    n_checks = 0;
    n_errors = 0;

    user_rst          = 1'b1;
    ctrl              = 32'h0;
    snap_bus.tx_data  = '0;
    snap_bus.tx_valid = 1'b0;
    snap_bus.ext_trig = 1'b0;
    #3;
    check("rst snap_addr", {32'd0, snap_addr}, 64'd0);
    check("rst we", {63'd0, snap_bus.bram_we}, 64'd0);
    check("rst addr", {60'd0, snap_bus.bram_addr}, 64'd0);
    check("rst din", snap_bus.bram_din, 64'd0);
    step();
    user_rst = 1'b0;
    step();
    step();
    check("idle no arm", {32'd0, snap_addr}, 64'd0);

    // immediate trigger, no gating
    ctrl = 32'h1;
    snap_bus.tx_data = 64'hFF;
    step();
    check("imm armed", {32'd0, snap_addr}, 64'h4000_0000);
    check_idle_we("imm arm cycle");
    for (int i = 0; i < 16; i++) begin
      snap_bus.tx_data = 64'h100 + 64'(i);
      step();
      check_write("imm", i, 64'h100 + 64'(i));
      check("imm status", {32'd0, snap_addr},
            {32'd0, (i == 15) ? 32'h8000_0010 : busy_word(i + 1)});
    end
    snap_bus.tx_data = 64'h999;
    step();
    check_idle_we("imm done hold");
    check("imm done status", {32'd0, snap_addr}, 64'h8000_0010);

    // external trigger
    ctrl = 32'h2;
    step();
    ctrl = 32'h3;
    snap_bus.tx_data = 64'h0;
    step();
    check("ext armed", {32'd0, snap_addr}, 64'h4000_0000);
    for (int k = 1; k <= 3; k++) begin
      snap_bus.tx_data = 64'h11 * 64'(k);
      step();
      check_idle_we("ext pre-trig");
      check("ext pre-trig status", {32'd0, snap_addr}, 64'h4000_0000);
    end
    snap_bus.tx_data  = 64'hAA;
    snap_bus.ext_trig = 1'b1;
    step();
    snap_bus.ext_trig = 1'b0;
    check_write("ext first", 0, 64'hAA);
    check("ext status1", {32'd0, snap_addr}, 64'h4000_0001);
    for (int i = 1; i < 16; i++) begin
      snap_bus.tx_data = 64'hB00 + 64'(i);
      step();
    end
    check_write("ext last", 15, 64'hB0F);
    check("ext done", {32'd0, snap_addr}, 64'h8000_0010);

    // valid gating, tx_valid toggling
    ctrl = 32'h0;
    step();
    ctrl = 32'h5;
    snap_bus.tx_valid = 1'b0;
    step();
    check("gate armed", {32'd0, snap_addr}, 64'h4000_0000);
    writes = 0;
    for (int c = 0; c < 32; c++) begin
      snap_bus.tx_valid = (c % 2 == 0);
      snap_bus.tx_data  = (c % 2 == 0) ? 64'h200 + 64'(c / 2) : 64'hDEAD_0000 + 64'(c);
      step();
      if (snap_bus.bram_we) writes++;
      words = c / 2 + 1;
      if (c % 2 == 0) check_write("gate valid", c / 2, 64'h200 + 64'(c / 2));
      else check_idle_we("gate invalid");
      check("gate status", {32'd0, snap_addr},
            {32'd0, (words == 16) ? 32'h8000_0010 : busy_word(words)});
    end
    check("gate write count", 64'(writes), 64'd16);
    snap_bus.tx_valid = 1'b0;

    // re-arm mid-capture
    ctrl = 32'h0;
    step();
    ctrl = 32'h1;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) ctrl = 32'h0;
      snap_bus.tx_data = 64'h300 + 64'(i);
      step();
    end
    check("rearm pre status", {32'd0, snap_addr}, 64'h4000_0005);
    ctrl = 32'h1;
    snap_bus.tx_data = 64'h305;
    step();
    check_idle_we("rearm edge");
    check("rearm status", {32'd0, snap_addr}, 64'h4000_0000);
    for (int i = 0; i < 7; i++) begin
      snap_bus.tx_data = 64'h306 + 64'(i);
      step();
      check_write("rearm cap", i, 64'h306 + 64'(i));
    end
    check("rearm held high", {32'd0, snap_addr}, 64'h4000_0007);

    // asynchronous reset at count 7
    #2;
    user_rst = 1'b1;
    #1;
    check("arst snap_addr", {32'd0, snap_addr}, 64'd0);
    check("arst we", {63'd0, snap_bus.bram_we}, 64'd0);
    check("arst addr", {60'd0, snap_bus.bram_addr}, 64'd0);
    check("arst din", snap_bus.bram_din, 64'd0);
    step();
    user_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      snap_bus.tx_valid = 1'b1;
      snap_bus.tx_data  = 64'h500 + 64'(i);
      step();
      check_idle_we("post-rst");
      check("post-rst status", {32'd0, snap_addr}, 64'd0);
    end

    // arm edge coinciding with valid data
    ctrl = 32'h0;
    step();
    ctrl = 32'h5;
    snap_bus.tx_valid = 1'b1;
    snap_bus.tx_data  = 64'h400;
    step();
    check_idle_we("coll arm");
    check("coll armed", {32'd0, snap_addr}, 64'h4000_0000);
    snap_bus.tx_valid = 1'b0;
    snap_bus.tx_data  = 64'h4FF;
    step();
    check_idle_we("coll gap");
    snap_bus.tx_valid = 1'b1;
    snap_bus.tx_data  = 64'h401;
    step();
    check_write("coll word0", 0, 64'h401);
    check("coll status", {32'd0, snap_addr}, 64'h4000_0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
